// File: rtl/alu_seq.sv
// Handshaked sequential ALU: shift-add, add-triple, negate, abs-diff, optional iterative mul.
// Define ALU_SEQ_MUL_EN to build the shift-add multiplier (op 100); otherwise op 100 is reserved.
module alu_seq #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
`ifdef ALU_SEQ_MUL_EN
    BUSY,
`endif
    DONE
  } state_t;

  localparam logic [2:0] OP_SHIFT = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_NEG   = 3'b010;
  localparam logic [2:0] OP_ABS   = 3'b011;

  state_t state;

  // single-cycle datapath
  logic [WIDTH-1:0]        a_sh;
  logic [WIDTH:0]          sh_sum;
  logic [WIDTH+1:0]        add_s;
  logic signed [WIDTH+1:0] abs_d;
  logic [WIDTH+1:0]        abs_m;
  logic [WIDTH-1:0]        neg_r;
  logic [WIDTH-1:0]        sc_out;
  logic                    sc_cout;
  logic                    sc_err;

  assign a_sh   = a << 2;
  assign sh_sum = {1'b0, a_sh} + {1'b0, b >> 1};
  assign add_s  = {2'b00, a} + {2'b00, b} + {1'b0, b, 1'b0};
  assign abs_d  = $signed({1'b0, a, 1'b0}) - $signed({2'b00, b});
  assign abs_m  = abs_d[WIDTH+1] ? $unsigned(-abs_d) : $unsigned(abs_d);
  assign neg_r  = {WIDTH{1'b0}} - b;

  always_comb begin
    sc_out  = '0;
    sc_cout = 1'b0;
    sc_err  = 1'b0;
    case (op_code)
      OP_SHIFT: begin sc_out = sh_sum[WIDTH-1:0]; sc_cout = sh_sum[WIDTH];           end
      OP_ADD:   begin sc_out = add_s[WIDTH-1:0];  sc_cout = |add_s[WIDTH+1:WIDTH];   end
      OP_NEG:   begin sc_out = neg_r;                                                end
      OP_ABS:   begin sc_out = abs_m[WIDTH-1:0];  sc_cout = |abs_m[WIDTH+1:WIDTH];   end
      default:  sc_err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int          CW     = $clog2(WIDTH + 1);
  localparam logic [2:0]  OP_MUL = 3'b100;

  // {m_hi, m_lo} is the shifting partial product; m_lo starts as the multiplier
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] m_hi_nx;
  logic [WIDTH-1:0] m_lo_nx;
  logic [WIDTH-1:0] hi_q;

  assign m_sum   = {1'b0, m_hi} + {1'b0, (m_lo[0] ? m_a : {WIDTH{1'b0}})};
  assign m_hi_nx = m_sum[WIDTH:1];
  assign m_lo_nx = {m_sum[0], m_lo[WIDTH-1:1]};
  assign out_hi  = hi_q;
`else
  assign out_hi  = '0;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign zero      = (out == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      out   <= '0;
      cout  <= 1'b0;
      err   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q  <= '0;
      m_a   <= '0;
      m_hi  <= '0;
      m_lo  <= '0;
      cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
            if (op_code == OP_MUL) begin
              m_a   <= a;
              m_hi  <= '0;
              m_lo  <= b;
              cnt   <= CW'(WIDTH);
              state <= BUSY;
            end else begin
              hi_q  <= '0;
`else
            begin
`endif
              out   <= sc_out;
              cout  <= sc_cout;
              err   <= sc_err;
              state <= DONE;
            end
          end
        end
`ifdef ALU_SEQ_MUL_EN
        BUSY: begin
          m_hi <= m_hi_nx;
          m_lo <= m_lo_nx;
          cnt  <= cnt - 1'b1;
          // the final iteration's result goes straight to the output registers
          if (cnt == CW'(1)) begin
            out   <= m_lo_nx;
            hi_q  <= m_hi_nx;
            cout  <= |m_hi_nx;
            err   <= 1'b0;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=6; mul scenarios follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] op_code = 3'b000;
  logic [5:0] a = '0;
  logic [5:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [5:0] out;
  logic [5:0] out_hi;
  logic       cout;
  logic       zero;
  logic       err;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op_code(op_code), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .cout(cout), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one op, return latency (accept cycle -> first out_valid) and whether in_ready rose meanwhile
  task automatic do_op(input logic [2:0] op, input logic [5:0] aa, input logic [5:0] bb,
                       output int lat, output bit rdy_seen);
    int n;
    in_valid = 1'b1; op_code = op; a = aa; b = bb;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    tick();
    in_valid = 1'b0;
    lat = 1; rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      tick(); lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out !== 6'd0 || out_hi !== 6'd0) begin errors++; $display("FAIL reset_out got %0d/%0d want 0/0", out, out_hi); end
    checks++; if (cout !== 1'b0 || err !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL reset_flags got c%b e%b z%b want c0 e0 z1", cout, err, zero); end
  endtask

  task automatic test_single(input string name, input logic [2:0] op, input logic [5:0] aa, input logic [5:0] bb,
                             input logic [5:0] exp_out, input logic exp_cout);
    int lat; bit rs;
    do_op(op, aa, bb, lat, rs);
    checks++; if (lat !== 1) begin errors++; $display("FAIL %s_latency got %0d want 1", name, lat); end
    checks++; if (out !== exp_out) begin errors++; $display("FAIL %s_out got %0d want %0d", name, out, exp_out); end
    checks++; if (cout !== exp_cout || err !== 1'b0) begin errors++; $display("FAIL %s_flags got c%b e%b want c%b e0", name, cout, err, exp_cout); end
    checks++; if (zero !== (exp_out == 6'd0) || out_hi !== 6'd0) begin errors++; $display("FAIL %s_zero_hi got z%b hi%0d want z%b hi0", name, zero, out_hi, exp_out == 6'd0); end
    consume();
  endtask

  task automatic test_alu_ops();
    test_single("shift", 3'b000, 6'd5, 6'd3, 6'd21, 1'b0);
    test_single("add", 3'b001, 6'd63, 6'd63, 6'd60, 1'b1);
    test_single("abs_neg_d", 3'b011, 6'd1, 6'd10, 6'd8, 1'b0);
    test_single("abs_ovf", 3'b011, 6'd63, 6'd0, 6'd62, 1'b1);
    test_single("neg1", 3'b010, 6'd7, 6'd1, 6'd63, 1'b0);
    test_single("neg0", 3'b010, 6'd7, 6'd0, 6'd0, 1'b0);
  endtask

  task automatic test_mul();
`ifdef ALU_SEQ_MUL_EN
    int lat; bit rs;
    do_op(3'b100, 6'd63, 6'd63, lat, rs);
    checks++; if (lat !== 7) begin errors++; $display("FAIL mul_latency got %0d want 7", lat); end
    checks++; if (rs !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got %b want 0", rs); end
    checks++; if (out !== 6'd1 || out_hi !== 6'd62) begin errors++; $display("FAIL mul_result got %0d/%0d want 1/62", out, out_hi); end
    checks++; if (cout !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL mul_flags got c%b e%b want c1 e0", cout, err); end
    consume();
    do_op(3'b100, 6'd0, 6'd45, lat, rs);
    checks++; if (zero !== 1'b1 || out_hi !== 6'd0 || cout !== 1'b0) begin errors++; $display("FAIL mul_zero got z%b hi%0d c%b want z1 hi0 c0", zero, out_hi, cout); end
    consume();
    do_op(3'b100, 6'd13, 6'd11, lat, rs);
    checks++; if (out !== 6'd15 || out_hi !== 6'd2) begin errors++; $display("FAIL mul_13x11 got %0d/%0d want 15/2", out, out_hi); end
    consume();
`endif
  endtask

  task automatic test_backpressure();
    int lat; bit rs;
    do_op(3'b001, 6'd2, 6'd1, lat, rs);
    in_valid = 1'b1; op_code = 3'b001; a = 6'd9; b = 6'd9;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out !== 6'd5 || out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got out%0d v%b r%b want out5 v1 r0", i, out, out_valid, in_ready); end
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out !== 6'd5) begin errors++; $display("FAIL bp_release got v%b r%b out%0d want v0 r1 out5", out_valid, in_ready, out); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out !== 6'd36) begin errors++; $display("FAIL bp_second got v%b out%0d want v1 out36", out_valid, out); end
    consume();
  endtask

  task automatic test_reset_midop();
    int lat; bit rs;
    in_valid = 1'b1; op_code = 3'b100; a = 6'd63; b = 6'd63;
    tick(); in_valid = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    tick(); tick();
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state got v%b r%b want v0 r1", out_valid, in_ready); end
    checks++; if (out !== 6'd0 || out_hi !== 6'd0 || cout !== 1'b0 || err !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL rst_mid_outputs got %0d/%0d c%b e%b z%b want 0/0 c0 e0 z1", out, out_hi, cout, err, zero); end
    do_op(3'b001, 6'd1, 6'd1, lat, rs);
    checks++; if (out !== 6'd4 || lat !== 1) begin errors++; $display("FAIL rst_mid_after got out%0d lat%0d want out4 lat1", out, lat); end
    consume();
  endtask

  task automatic test_reserved(input logic [2:0] op);
    int lat; bit rs;
    do_op(op, 6'd5, 6'd7, lat, rs);
    checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL rsvd%0d_err got lat%0d e%b want lat1 e1", op, lat, err); end
    checks++; if (out !== 6'd0 || out_hi !== 6'd0 || cout !== 1'b0 || zero !== 1'b1) begin errors++; $display("FAIL rsvd%0d_out got %0d/%0d c%b z%b want 0/0 c0 z1", op, out, out_hi, cout, zero); end
    consume();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    in_valid = 1'b1; op_code = 3'b000; a = 6'd5; b = 6'd3; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0; tick(); out_ready = 1'b0;
    checks++; if (acc !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", acc); end
    checks++; if (out !== 6'd21 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_final got out%0d r%b want out21 r1", out, in_ready); end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mul();
    test_backpressure();
    test_reset_midop();
    test_reserved(3'b110);
    test_reserved(3'b111);
`ifndef ALU_SEQ_MUL_EN
    test_reserved(3'b100);
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
